// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI arbiter.
//   arb_state_e : arbiter FSM encoding (idle, grant held, byte in flight, release gap)
//   SPI_DW      : byte width of the spi_master data path
//   DC_CMD/DC_DATA : values of the D/C line for command and data bytes
package oled_pkg;

  localparam int unsigned SPI_DW = 8;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGrant   = 2'd1,
    StWait    = 2'd2,
    StRelease = 2'd3
  } arb_state_e;

endpackage

// File: rtl/oled_spi_arbiter_if.sv
// Bundle between the OLED sequencers, the arbiter and spi_master.
//   slave  : arbiter view (takes requests and spi_send_done, drives grants and the SPI byte)
//   master : requester/spi_master view (drives requests, bytes and spi_send_done)
// Signals:
//   req, byte_vld, byte_dc [N_REQ]  per-requester request, byte valid, D/C bit
//   byte_data [N_REQ*DW]            flattened bytes, slice i belongs to requester i
//   gnt, byte_done [N_REQ]          one-hot ownership, per-byte completion pulse
//   spi_send, spi_data, spi_dc      start pulse and byte towards spi_master
//   spi_send_done                   completion pulse from spi_master
//   busy, bytes_sent                grant held, bytes finished in current/last grant
interface oled_spi_arbiter_if #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned DW    = 8,
  parameter int unsigned CNT_W = 16
);

  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    byte_vld;
  logic [N_REQ*DW-1:0] byte_data;
  logic [N_REQ-1:0]    byte_dc;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    byte_done;
  logic                spi_send;
  logic [DW-1:0]       spi_data;
  logic                spi_dc;
  logic                spi_send_done;
  logic                busy;
  logic [CNT_W-1:0]    bytes_sent;

  modport slave (
    input  req, byte_vld, byte_data, byte_dc, spi_send_done,
    output gnt, byte_done, spi_send, spi_data, spi_dc, busy, bytes_sent
  );

  modport master (
    output req, byte_vld, byte_data, byte_dc, spi_send_done,
    input  gnt, byte_done, spi_send, spi_data, spi_dc, busy, bytes_sent
  );

endinterface

// File: rtl/oled_arb_pick.sv
// Combinational one-hot winner select.
// The search starts at (i_ptr + 1) mod N_REQ and takes the first set request from there.
// Driving i_ptr with a constant N_REQ-1 gives plain fixed priority (index 0 highest);
// driving it with the last owner gives round-robin.
//   i_req [N_REQ]  request vector
//   i_ptr [PTR_W]  index the search starts after
//   o_gnt [N_REQ]  one-hot winner, all zero when no request
module oled_arb_pick #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt
);

  int unsigned      w_start;
  logic [N_REQ-1:0] w_rot;
  logic [N_REQ-1:0] w_low;

  always_comb begin
    w_start = (32'(i_ptr) + 32'd1) % N_REQ;
    // Rotate so the search start sits at bit 0, isolate the lowest set bit, rotate back.
    w_rot   = N_REQ'({i_req, i_req} >> w_start);
    w_low   = w_rot & (~w_rot + N_REQ'(1));
    o_gnt   = N_REQ'({w_low, w_low} >> (N_REQ - w_start));
  end

endmodule

// File: rtl/oled_spi_arbiter.sv
// Shares one byte-wide spi_master between N_REQ OLED sequencers.
// An owner keeps the grant for a whole multi-byte transaction; bytes go out one at a time
// and each completion is returned to the owner as a byte_done pulse.
// Ports:
//   i_clk      system clock
//   i_reset_n  asynchronous active-low reset
//   bus        oled_spi_arbiter_if.slave (requests, grants, SPI byte path, status)
// Build option: OLED_ARB_RR_EN selects round-robin arbitration; fixed priority otherwise.
module oled_spi_arbiter
  import oled_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned DW    = SPI_DW,
  parameter int unsigned CNT_W = 16
) (
  input logic               i_clk,
  input logic               i_reset_n,
  oled_spi_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e       r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [N_REQ-1:0] r_byte_done, w_byte_done_nxt;
  logic             r_spi_send, w_spi_send_nxt;
  logic [DW-1:0]    r_spi_data, w_spi_data_nxt;
  logic             r_spi_dc, w_spi_dc_nxt;
  logic [CNT_W-1:0] r_bytes_sent, w_bytes_sent_nxt;

  logic [N_REQ-1:0] w_win;
  logic [PTR_W-1:0] w_ptr;
  logic [DW-1:0]    w_own_data;
  logic             w_own_dc;
  logic             w_own_req;
  logic             w_own_vld;

  oled_arb_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .i_req (bus.req),
    .i_ptr (w_ptr),
    .o_gnt (w_win)
  );

`ifdef OLED_ARB_RR_EN
  logic [PTR_W-1:0] r_last;
  logic [PTR_W-1:0] w_win_idx;

  always_comb begin
    w_win_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_win[i]) w_win_idx = PTR_W'(i);
    end
  end

  // Reset value N_REQ-1 makes requester 0 the first winner.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_last <= PTR_W'(N_REQ - 1);
    end else if (r_state == StIdle && |bus.req) begin
      r_last <= w_win_idx;
    end
  end

  assign w_ptr = r_last;
`else
  assign w_ptr = PTR_W'(N_REQ - 1);
`endif

  // Owner-side selection; r_gnt is one-hot or zero.
  always_comb begin
    w_own_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (r_gnt[i]) w_own_data = bus.byte_data[i*DW +: DW];
    end
  end

  assign w_own_dc  = |(bus.byte_dc & r_gnt);
  assign w_own_req = |(bus.req & r_gnt);
  assign w_own_vld = |(bus.byte_vld & r_gnt);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= StIdle;
      r_gnt        <= '0;
      r_byte_done  <= '0;
      r_spi_send   <= 1'b0;
      r_spi_data   <= '0;
      r_spi_dc     <= 1'b0;
      r_bytes_sent <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_gnt        <= w_gnt_nxt;
      r_byte_done  <= w_byte_done_nxt;
      r_spi_send   <= w_spi_send_nxt;
      r_spi_data   <= w_spi_data_nxt;
      r_spi_dc     <= w_spi_dc_nxt;
      r_bytes_sent <= w_bytes_sent_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_gnt_nxt        = r_gnt;
    w_byte_done_nxt  = '0;
    w_spi_send_nxt   = 1'b0;
    w_spi_data_nxt   = r_spi_data;
    w_spi_dc_nxt     = r_spi_dc;
    w_bytes_sent_nxt = r_bytes_sent;

    unique case (r_state)
      StIdle: begin
        if (|bus.req) begin
          w_state_nxt      = StGrant;
          w_gnt_nxt        = w_win;
          w_bytes_sent_nxt = '0;
        end
      end
      StGrant: begin
        if (!w_own_req) begin
          w_state_nxt = StRelease;
          w_gnt_nxt   = '0;
        end else if (w_own_vld) begin
          w_state_nxt    = StWait;
          w_spi_send_nxt = 1'b1;
          w_spi_data_nxt = w_own_data;
          w_spi_dc_nxt   = w_own_dc;
        end
      end
      StWait: begin
        // A completion in the same cycle as our own start pulse cannot belong to this byte.
        if (bus.spi_send_done && !r_spi_send) begin
          w_state_nxt     = StGrant;
          w_byte_done_nxt = r_gnt;
          if (r_bytes_sent != {CNT_W{1'b1}}) begin
            w_bytes_sent_nxt = r_bytes_sent + CNT_W'(1);
          end
        end
      end
      StRelease: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  assign bus.gnt        = r_gnt;
  assign bus.byte_done  = r_byte_done;
  assign bus.spi_send   = r_spi_send;
  assign bus.spi_data   = r_spi_data;
  assign bus.spi_dc     = r_spi_dc;
  assign bus.busy       = |r_gnt;
  assign bus.bytes_sent = r_bytes_sent;

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Directed bench for oled_spi_arbiter: a per-cycle vector table for single-owner traffic
// and stray inputs, plus hand-written sequences for reset, contention and early release.
module tb_oled_spi_arbiter;
  import oled_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  oled_spi_arbiter_if #(.N_REQ(3), .DW(8), .CNT_W(16)) bus ();

  oled_spi_arbiter #(
    .N_REQ (3),
    .DW    (8),
    .CNT_W (16)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  vld;
    logic [23:0] data;
    logic [2:0]  dc;
    logic        done;
    logic [2:0]  e_gnt;
    logic        e_send;
    logic [7:0]  e_data;
    logic        e_dc;
    logic [2:0]  e_bd;
    logic        e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [2:0] req, input logic [2:0] vld,
                              input logic [23:0] data, input logic [2:0] dc, input logic done,
                              input logic [2:0] e_gnt, input logic e_send, input logic [7:0] e_data,
                              input logic e_dc, input logic [2:0] e_bd, input logic e_busy,
                              input logic [15:0] e_cnt);
    vec_t v;
    v.req = req; v.vld = vld; v.data = data; v.dc = dc; v.done = done;
    v.e_gnt = e_gnt; v.e_send = e_send; v.e_data = e_data; v.e_dc = e_dc;
    v.e_bd = e_bd; v.e_busy = e_busy; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " gnt"},   32'(bus.gnt), 32'd0);
    chk({nm, " bd"},    32'(bus.byte_done), 32'd0);
    chk({nm, " send"},  32'(bus.spi_send), 32'd0);
    chk({nm, " data"},  32'(bus.spi_data), 32'd0);
    chk({nm, " dc"},    32'(bus.spi_dc), 32'd0);
    chk({nm, " busy"},  32'(bus.busy), 32'd0);
    chk({nm, " count"}, 32'(bus.bytes_sent), 32'd0);
  endtask

  task automatic wait_gnt(input logic [2:0] want, input string nm);
    int n;
    n = 0;
    while (bus.gnt == 3'b000 && n < 8) begin
      tick();
      n++;
    end
    chk(nm, 32'(bus.gnt), 32'(want));
  endtask

  // One byte from the current owner, with spi_send_done one cycle after the send pulse.
  // Ends on the byte_done cycle (arbiter back in its grant state).
  task automatic send_byte(input int idx, input logic [7:0] d, input logic dc, input string nm);
    logic [2:0] one;
    one = 3'b001 << idx;
    bus.byte_vld = one;
    bus.byte_data[idx*8 +: 8] = d;
    bus.byte_dc[idx] = dc;
    tick();
    chk({nm, " send"}, 32'(bus.spi_send), 32'd1);
    chk({nm, " data"}, 32'(bus.spi_data), 32'(d));
    chk({nm, " dc"},   32'(bus.spi_dc), 32'(dc));
    bus.byte_vld = 3'b000;
    tick();
    bus.spi_send_done = 1'b1;
    tick();
    bus.spi_send_done = 1'b0;
    chk({nm, " done"}, 32'(bus.byte_done), 32'(one));
  endtask

`ifdef OLED_ARB_RR_EN
  int order[4] = '{0, 1, 2, 0};
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req = '0;
    bus.byte_vld = '0;
    bus.byte_data = '0;
    bus.byte_dc = '0;
    bus.spi_send_done = 1'b0;

    // Reset state
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    chk_all_zero("post reset idle");

    // Reset asserted while a byte is in flight
    bus.req = 3'b010;
    tick();
    chk("rst-mid gnt", 32'(bus.gnt), 32'h2);
    bus.byte_vld = 3'b010;
    bus.byte_data = 24'h00AE00;
    tick();
    chk("rst-mid send", 32'(bus.spi_send), 32'd1);
    bus.byte_vld = 3'b000;
    tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst-mid async");
    bus.req = 3'b000;
    tick();
    rst_n = 1'b1;
    bus.spi_send_done = 1'b1;
    tick();
    bus.spi_send_done = 1'b0;
    chk("rst-mid no bd", 32'(bus.byte_done), 32'd0);
    chk("rst-mid no gnt", 32'(bus.gnt), 32'd0);
    bus.req = 3'b010;
    tick();
    chk("rst-mid idle regrant", 32'(bus.gnt), 32'h2);
    bus.req = 3'b000;
    tick();
    tick();

    // Vector table: single owner two bytes, release, stray done and non-owner byte_vld
    vecs[0]  = mk(3'b010, 3'b000, 24'h0,      3'b000, 0, 3'b010, 0, 8'h00, 0, 3'b000, 1, 16'd0);
    vecs[1]  = mk(3'b010, 3'b010, 24'h00AE00, 3'b000, 0, 3'b010, 1, 8'hAE, 0, 3'b000, 1, 16'd0);
    vecs[2]  = mk(3'b010, 3'b000, 24'h0,      3'b000, 0, 3'b010, 0, 8'hAE, 0, 3'b000, 1, 16'd0);
    vecs[3]  = mk(3'b010, 3'b000, 24'h0,      3'b000, 1, 3'b010, 0, 8'hAE, 0, 3'b010, 1, 16'd1);
    vecs[4]  = mk(3'b010, 3'b010, 24'h00A500, 3'b010, 0, 3'b010, 1, 8'hA5, 1, 3'b000, 1, 16'd1);
    vecs[5]  = mk(3'b010, 3'b000, 24'h0,      3'b000, 0, 3'b010, 0, 8'hA5, 1, 3'b000, 1, 16'd1);
    vecs[6]  = mk(3'b010, 3'b000, 24'h0,      3'b000, 1, 3'b010, 0, 8'hA5, 1, 3'b010, 1, 16'd2);
    vecs[7]  = mk(3'b000, 3'b000, 24'h0,      3'b000, 0, 3'b000, 0, 8'hA5, 1, 3'b000, 0, 16'd2);
    vecs[8]  = mk(3'b000, 3'b000, 24'h0,      3'b000, 0, 3'b000, 0, 8'hA5, 1, 3'b000, 0, 16'd2);
    vecs[9]  = mk(3'b000, 3'b000, 24'h0,      3'b000, 1, 3'b000, 0, 8'hA5, 1, 3'b000, 0, 16'd2);
    vecs[10] = mk(3'b001, 3'b000, 24'h0,      3'b000, 0, 3'b001, 0, 8'hA5, 1, 3'b000, 1, 16'd0);
    vecs[11] = mk(3'b001, 3'b001, 24'h00003C, 3'b000, 0, 3'b001, 1, 8'h3C, 0, 3'b000, 1, 16'd0);
    vecs[12] = mk(3'b001, 3'b000, 24'h0,      3'b000, 0, 3'b001, 0, 8'h3C, 0, 3'b000, 1, 16'd0);
    vecs[13] = mk(3'b001, 3'b000, 24'h0,      3'b000, 1, 3'b001, 0, 8'h3C, 0, 3'b001, 1, 16'd1);
    vecs[14] = mk(3'b001, 3'b010, 24'h007700, 3'b010, 1, 3'b001, 0, 8'h3C, 0, 3'b000, 1, 16'd1);
    vecs[15] = mk(3'b001, 3'b000, 24'h0,      3'b000, 1, 3'b001, 0, 8'h3C, 0, 3'b000, 1, 16'd1);
    vecs[16] = mk(3'b000, 3'b000, 24'h0,      3'b000, 0, 3'b000, 0, 8'h3C, 0, 3'b000, 0, 16'd1);
    vecs[17] = mk(3'b000, 3'b000, 24'h0,      3'b000, 0, 3'b000, 0, 8'h3C, 0, 3'b000, 0, 16'd1);

    for (int i = 0; i < NV; i++) begin
      bus.req = vecs[i].req;
      bus.byte_vld = vecs[i].vld;
      bus.byte_data = vecs[i].data;
      bus.byte_dc = vecs[i].dc;
      bus.spi_send_done = vecs[i].done;
      tick();
      chk($sformatf("v%0d gnt", i),   32'(bus.gnt), 32'(vecs[i].e_gnt));
      chk($sformatf("v%0d send", i),  32'(bus.spi_send), 32'(vecs[i].e_send));
      chk($sformatf("v%0d data", i),  32'(bus.spi_data), 32'(vecs[i].e_data));
      chk($sformatf("v%0d dc", i),    32'(bus.spi_dc), 32'(vecs[i].e_dc));
      chk($sformatf("v%0d bd", i),    32'(bus.byte_done), 32'(vecs[i].e_bd));
      chk($sformatf("v%0d busy", i),  32'(bus.busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d count", i), 32'(bus.bytes_sent), 32'(vecs[i].e_cnt));
    end
    bus.spi_send_done = 1'b0;
    bus.byte_vld = '0;

    // Simultaneous requests, then hand-over after release
    bus.req = 3'b110;
    tick();
    chk("contend first gnt", 32'(bus.gnt), 32'h2);
    send_byte(1, 8'h11, DC_CMD, "contend b1");
    bus.req = 3'b100;
    tick();
    chk("contend gap", 32'(bus.gnt), 32'h0);
    wait_gnt(3'b100, "contend second gnt");
    chk("contend count cleared", 32'(bus.bytes_sent), 32'd0);

    // Higher priority request arriving during a grant waits
    bus.req = 3'b101;
    tick();
    tick();
    chk("no preempt", 32'(bus.gnt), 32'h4);
    bus.req = 3'b001;
    tick();
    chk("preempt gap", 32'(bus.gnt), 32'h0);
    wait_gnt(3'b001, "waiter gnt");
    bus.req = 3'b000;
    tick();
    tick();

    // Owner drops req while its byte is on the wire
    bus.req = 3'b100;
    tick();
    chk("early gnt", 32'(bus.gnt), 32'h4);
    bus.byte_vld = 3'b100;
    bus.byte_data = 24'hC30000;
    bus.byte_dc = 3'b100;
    tick();
    chk("early send", 32'(bus.spi_send), 32'd1);
    bus.req = 3'b000;
    bus.byte_vld = 3'b000;
    tick();
    chk("early hold gnt", 32'(bus.gnt), 32'h4);
    chk("early hold data", 32'(bus.spi_data), 32'hC3);
    bus.spi_send_done = 1'b1;
    tick();
    bus.spi_send_done = 1'b0;
    chk("early bd", 32'(bus.byte_done), 32'h4);
    chk("early data stable", 32'(bus.spi_data), 32'hC3);
    chk("early dc stable", 32'(bus.spi_dc), 32'd1);
    tick();
    chk("early release gnt", 32'(bus.gnt), 32'h0);
    chk("early release busy", 32'(bus.busy), 32'd0);
    tick();
    chk("early count", 32'(bus.bytes_sent), 32'd1);

`ifdef OLED_ARB_RR_EN
    // Round-robin order from a fresh pointer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req = 3'b111;
    tick();
    chk("rr first gnt", 32'(bus.gnt), 32'h1);
    for (int k = 0; k < 4; k++) begin
      send_byte(order[k], 8'(8'h50 + k), DC_DATA, $sformatf("rr%0d", k));
      bus.req[order[k]] = 1'b0;
      tick();
      chk($sformatf("rr%0d gap", k), 32'(bus.gnt), 32'h0);
      if (k < 3) begin
        bus.req[order[k]] = 1'b1;
        wait_gnt(3'b001 << order[k+1], $sformatf("rr%0d next gnt", k));
      end else begin
        bus.req = 3'b000;
      end
    end
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
